// File: rtl/wide_add_seq_pkg.sv
// Shared types and constants for the word-serial wide adder/subtractor.
// The FSM states and the slice width live here so the datapath and bench agree.
package wide_add_seq_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Word index width; a single-word operand still needs a 1-bit index.
    function automatic int idx_width(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/wide_add_seq_adder.sv
// 32-bit ripple adder slice with carry in, carry out and signed overflow.
// Shared by every word of the wide operation, one word per cycle.
module adder
    import wide_add_seq_pkg::*;
(
    input  logic [WORD_W-1:0] A,
    input  logic [WORD_W-1:0] B,
    input  logic              CIN,
    output logic [WORD_W-1:0] Y,
    output logic              C,
    output logic              V
);

    logic [WORD_W:0] sum_ext;

    assign sum_ext = {1'b0, A} + {1'b0, B} + {{WORD_W{1'b0}}, CIN};
    assign Y       = sum_ext[WORD_W-1:0];
    assign C       = sum_ext[WORD_W];
    // Overflow: like-signed inputs producing a result of the other sign.
    assign V       = (A[WORD_W-1] == B[WORD_W-1]) && (Y[WORD_W-1] != A[WORD_W-1]);

endmodule

// File: rtl/wide_add_seq.sv
// Word-serial WORDS x 32-bit add/subtract: one shared 32-bit adder walks the
// operands LSW first, chaining the carry, with a valid/ready result handshake.
module wide_add_seq
    import wide_add_seq_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start_valid,
    output logic                    start_ready,
    input  logic                    op_sub,
    input  logic [WORD_W*WORDS-1:0] a_in,
    input  logic [WORD_W*WORDS-1:0] b_in,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [WORD_W*WORDS-1:0] result,
    output logic                    carry_out,
    output logic                    overflow,
    output logic                    busy
);

    localparam int                W        = WORD_W * WORDS;
    localparam int                IDX_W    = idx_width(WORDS);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(WORDS - 1);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               cy_q, cy_d;
    logic [W-1:0]       res_q, res_d;
    logic               co_q, co_d;
    logic               ov_q, ov_d;

    // Operand capture; only the accepting cycle may update these.
    logic [W-1:0]       a_q, b_q;
    logic               op_q;
    logic               accept;

    logic [WORD_W-1:0]  a_word, b_word, b_add, sum;
    logic               add_c, add_v;

    always_comb begin
        a_word = '0;
        b_word = '0;
        for (int w = 0; w < WORDS; w++) begin
            if (idx_q == IDX_W'(w)) begin
                a_word = a_q[w*WORD_W +: WORD_W];
                b_word = b_q[w*WORD_W +: WORD_W];
            end
        end
    end

    // Subtraction is A + ~B + 1; the +1 enters through the initial carry.
    assign b_add = op_q ? ~b_word : b_word;

    adder u_adder (
        .A   (a_word),
        .B   (b_add),
        .CIN (cy_q),
        .Y   (sum),
        .C   (add_c),
        .V   (add_v)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cy_d    = cy_q;
        res_d   = res_q;
        co_d    = co_q;
        ov_d    = ov_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_valid) begin
                    accept  = 1'b1;
                    idx_d   = '0;
                    cy_d    = op_sub;
                    state_d = RUN;
                end
            end
            RUN: begin
                for (int w = 0; w < WORDS; w++) begin
                    if (idx_q == IDX_W'(w)) begin
                        res_d[w*WORD_W +: WORD_W] = sum;
                    end
                end
                cy_d = add_c;
                if (idx_q == LAST_IDX) begin
                    // Top word: its carry and overflow describe the whole result.
                    co_d    = add_c;
                    ov_d    = add_v;
                    idx_d   = '0;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cy_q    <= 1'b0;
            res_q   <= '0;
            co_q    <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cy_q    <= cy_d;
            res_q   <= res_d;
            co_q    <= co_d;
            ov_q    <= ov_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            a_q  <= a_in;
            b_q  <= b_in;
            op_q <= op_sub;
        end
    end

    assign start_ready = (state_q == IDLE);
    assign res_valid   = (state_q == DONE);
    assign busy        = (state_q != IDLE);
    assign result      = res_q;
    assign carry_out   = co_q;
    assign overflow    = ov_q;

endmodule

// File: doc/wide_add_seq.md
WIDE_ADD_SEQ -- requirements
Module: wide_add_seq

Interface
REQ-001 The block SHALL provide parameter WORDS, default 4: number of 32-bit words per operand; legal range 1..8.
REQ-002 The block SHALL provide port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL provide port rst_n, input, 1: reset, asynchronous and active-low.
REQ-004 The block SHALL provide port start_valid, input, 1: a new operation is offered.
REQ-005 The block SHALL provide port start_ready, output, 1: the block accepts an operation this cycle.
REQ-006 The block SHALL provide port op_sub, input, 1: operation select, 0 = A+B, 1 = A-B.
REQ-007 The block SHALL provide port a_in, input, 32*WORDS: operand A, word 0 least significant.
REQ-008 The block SHALL provide port b_in, input, 32*WORDS: operand B, same layout.
REQ-009 The block SHALL provide port res_valid, output, 1: result outputs are valid.
REQ-010 The block SHALL provide port res_ready, input, 1: the consumer takes the result.
REQ-011 The block SHALL provide port result, output, 32*WORDS: the sum or difference.
REQ-012 The block SHALL provide port carry_out, output, 1: carry out of the top bit; for subtract, 1 = no borrow.
REQ-013 The block SHALL provide port overflow, output, 1: signed two's-complement overflow of the full-width result.
REQ-014 The block SHALL provide port busy, output, 1: high in RUN and DONE.

Function
REQ-015 The FSM SHALL have exactly three states, IDLE, RUN and DONE; start_ready SHALL equal (state==IDLE).
REQ-016 In IDLE, on start_valid&&start_ready, the block SHALL latch a_in, b_in and op_sub, clear the word index to 0, set the internal carry to op_sub, and enter RUN.
REQ-017 In RUN, each cycle SHALL process word idx through one shared 32-bit adder.
REQ-018 In that adder, A SHALL be the A word, B SHALL be the B word inverted when op_sub=1, and CIN SHALL be the internal carry.
REQ-019 Each RUN cycle SHALL write the adder sum into result word idx, load the internal carry with the adder carry and increment idx.
REQ-020 When idx==WORDS-1, the block SHALL load carry_out from the adder carry and overflow from the adder overflow, then enter DONE.
REQ-021 Latency SHALL be exactly WORDS cycles: res_valid rises on the WORDS-th rising edge after the accepting edge.
REQ-022 In DONE, res_valid SHALL be 1, and result, carry_out and overflow SHALL hold stable until res_valid&&res_ready.
REQ-023 On res_valid&&res_ready, the block SHALL return to IDLE; no start is accepted in that same cycle, so back-to-back operations are separated by one IDLE cycle.
REQ-024 Input changes on a_in, b_in or op_sub outside the accepting cycle SHALL have no effect on the operation in flight.
REQ-025 The result, carry_out and overflow outputs SHALL keep their last values in IDLE; only res_valid qualifies them.
REQ-026 The word index SHALL be $clog2(WORDS) bits wide (minimum 1) and SHALL never exceed WORDS-1.

Reset
REQ-027 rst_n low SHALL, asynchronously and at any time including mid-RUN, force state=IDLE, idx=0, internal carry=0, result=0, carry_out=0, overflow=0, res_valid=0 and busy=0.
REQ-028 start_ready SHALL be 1 while rst_n is low, since the state is IDLE.
REQ-029 An operation interrupted by reset SHALL be discarded, with no partial res_valid.

Structure
REQ-030 Package wide_add_seq_pkg SHALL hold the state enum (IDLE, RUN, DONE) and the constant WORD_W=32.
REQ-031 The design SHALL instantiate exactly one existing 32-bit adder sub-module, adder, with ports A, B, CIN, Y, C and V; no other arithmetic SHALL be inferred.

Verification (WORDS=4)
REQ-032 The bench SHALL check: A=all-ones (128 bits), B=1, add -> result=0, carry_out=1, overflow=0, res_valid 4 cycles after accept.
REQ-033 The bench SHALL check: A=0, B=1, sub -> result=all-ones, carry_out=0, overflow=0.
REQ-034 The bench SHALL check: A=0x7FFF_FFFF followed by 96 one bits, B=1, add -> result=0x8000_0000 followed by 96 zero bits, overflow=1, carry_out=0.
REQ-035 The bench SHALL check: res_ready low for 5 cycles in DONE -> res_valid, result and flags are stable, start_ready=0, and busy=1 throughout.
REQ-036 The bench SHALL check: rst_n pulsed low after 2 RUN cycles -> all outputs zero immediately, start_ready=1, and no res_valid after release.
REQ-037 The bench SHALL check: start_valid and res_ready held high with two operations -> second accept occurs one cycle after the first result handshake, and both results are correct.
